// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter.
// The master modport belongs to the arbiter, the slave modport to its environment.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         ack;
  logic [NREQ-1:0]         grant;
  logic                    busy;
  logic                    fifo_full;
  logic                    fifo_wr;
  logic [DW-1:0]           fifo_data_in;

  modport master (
    input  req, req_data, fifo_full,
    output ack, grant, busy, fifo_wr, fifo_data_in
  );

  modport slave (
    output req, req_data, fifo_full,
    input  ack, grant, busy, fifo_wr, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: NREQ producers share one FIFO write port,
// each grant lasting at most MAX_BURST accepted beats before rotation.
module fifo_wr_arbiter_lane #(
  parameter int DW = 8
) (
  input  logic          grant,
  input  logic          req,
  input  logic          wr_en,
  input  logic [DW-1:0] data,
  output logic          ack,
  output logic [DW-1:0] data_sel
);
  assign ack      = grant & req & wr_en;
  assign data_sel = grant ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input logic               clock,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;

  logic                    wr_en;
  logic [NREQ-1:0]         lane_ack;
  logic [NREQ-1:0][DW-1:0] lane_data;
  logic                    fifo_wr_c;
  logic [PW-1:0]           owner_idx;
  logic [PW-1:0]           next_ptr;
  logic [PW-1:0]           pick_ptr;
  logic [NREQ-1:0]         pick_oh;
  logic                    pick_vld;
  logic                    release_c;

  assign wr_en = ~bus.fifo_full;

  // Grant is one-hot, so at most one lane can ack and drive data.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DW(DW)) u_lane (
      .grant    (grant_q[i]),
      .req      (bus.req[i]),
      .wr_en    (wr_en),
      .data     (bus.req_data[i]),
      .ack      (lane_ack[i]),
      .data_sel (lane_data[i])
    );
  end

  assign fifo_wr_c = |lane_ack;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_q[i]) owner_idx = PW'(i);
  end

  assign next_ptr  = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
  assign release_c = (state_q == GRANT) &&
                     (~|(grant_q & bus.req) ||
                      (fifo_wr_c && beat_cnt_q == BW'(MAX_BURST - 1)));
  // A releasing owner re-arbitrates from the rotated pointer in the same cycle.
  assign pick_ptr  = release_c ? next_ptr : rr_ptr_q;

  always_comb begin
    int idx;
    pick_oh  = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(pick_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld     = 1'b1;
        pick_oh[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          grant_d    = pick_oh;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (fifo_wr_c) beat_cnt_d = beat_cnt_q + 1'b1;
        if (release_c) begin
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
          if (pick_vld) begin
            grant_d = pick_oh;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.grant        = grant_q;
    bus.busy         = (state_q == GRANT);
    bus.ack          = lane_ack;
    bus.fifo_wr      = fifo_wr_c;
    bus.fifo_data_in = '0;
    for (int i = 0; i < NREQ; i++)
      bus.fifo_data_in = bus.fifo_data_in | lane_data[i];
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scenario tasks plus a randomized run, checked
// cycle by cycle against an owner/pointer/burst reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int W    = 2 * NREQ + 2 + DW;

  logic clock = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // producer state: beats still to send and next sequence number
  int rem [NREQ];
  int seq [NREQ];
  // reference model: owner (-1 idle), rotation pointer, beats in this grant
  int m_own, m_ptr, m_cnt;
  logic [DW-1:0] wq[$];

  function automatic logic [DW-1:0] tag(input int i, input int s);
    logic [31:0] a, b;
    a = i; b = s;
    return {a[1:0], b[5:0]};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic drive(input logic full_i);
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]      = (rem[i] > 0);
      bus.req_data[i] = tag(i, seq[i]);
    end
    bus.fifo_full = full_i;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 0; end
    drive(1'b0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    m_own = -1; m_ptr = 0; m_cnt = 0;
    wq.delete();
  endtask

  // One clock: drive inputs, capture DUT and model views at negedge, advance.
  task automatic step(input logic full_i, output logic [W-1:0] obs, output logic [W-1:0] exp);
    logic [NREQ-1:0] r, g;
    logic            wr, rel;
    logic [DW-1:0]   d;
    drive(full_i);
    @(negedge clock);
    r  = bus.req;
    g  = (m_own < 0) ? '0 : (NREQ'(1) << m_own);
    wr = (m_own >= 0) ? (r[m_own] && !full_i) : 1'b0;
    d  = (m_own >= 0) ? tag(m_own, seq[m_own]) : '0;
    exp = {g, wr, (wr ? g : NREQ'(0)), (m_own >= 0), d};
    obs = {bus.grant, bus.fifo_wr, bus.ack, bus.busy, bus.fifo_data_in};
    if (bus.fifo_wr) wq.push_back(bus.fifo_data_in);
    if (m_own < 0) begin
      if (r != 0) begin m_own = pick(r, m_ptr); m_cnt = 0; end
    end else begin
      rel = !r[m_own] || (wr && m_cnt == MB - 1);
      if (wr) begin
        m_cnt++;
        rem[m_own]--;
        seq[m_own]++;
      end
      if (rel) begin
        m_ptr = (m_own + 1) % NREQ;
        m_cnt = 0;
        m_own = pick(r, m_ptr);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 3; seq[i] = i; end
    drive(1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({bus.grant, bus.fifo_wr, bus.ack, bus.busy, bus.fifo_data_in} !== W'(0)) begin
      bad++;
      $display("FAIL reset_state got grant=%b wr=%b ack=%b busy=%b data=%h want all zero",
               bus.grant, bus.fifo_wr, bus.ack, bus.busy, bus.fifo_data_in);
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    logic [W-1:0] obs, exp;
    int wrs = 0;
    apply_reset();
    rem[2] = 6;
    for (int c = 0; c < 9; c++) begin
      step(1'b0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL single_burst cyc=%0d got=%h want=%h", c, obs, exp); end
      if (c == 1) begin
        total++;
        if (obs[W-1 -: NREQ] !== 4'b0100) begin bad++; $display("FAIL single_burst_grant got=%b want=0100", obs[W-1 -: NREQ]); end
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if (obs[W-NREQ-1] !== 1'b1) begin bad++; $display("FAIL single_burst_gap cyc=%0d got wr=%b want 1", c, obs[W-NREQ-1]); end
      end
      wrs += int'(obs[W-NREQ-1]);
    end
    total++;
    if (wrs != 6) begin bad++; $display("FAIL single_burst_count got=%0d want=6", wrs); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] obs, exp;
    int grp;
    apply_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 8;
    for (int c = 0; c < 18; c++) begin
      step(1'b0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL round_robin cyc=%0d got=%h want=%h", c, obs, exp); end
    end
    total++;
    if (wq.size() != 17) begin bad++; $display("FAIL rr_count got=%0d want=17", wq.size()); end
    for (int b = 0; b < 17 && b < wq.size(); b++) begin
      grp = b / MB;
      total++;
      if (wq[b] !== tag(grp % NREQ, (grp / NREQ) * MB + b % MB)) begin
        bad++;
        $display("FAIL rr_order beat=%0d got=%h want=%h", b, wq[b], tag(grp % NREQ, (grp / NREQ) * MB + b % MB));
      end
    end
  endtask

  task automatic test_full_stall();
    logic [W-1:0] obs, exp;
    logic         full;
    apply_reset();
    rem[1] = 4;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 2 && c <= 4);
      step(full, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL full_stall cyc=%0d got=%h want=%h", c, obs, exp); end
      if (full) begin
        total++;
        if (obs[W-1 -: NREQ+1+NREQ] !== {4'b0010, 1'b0, 4'b0000}) begin
          bad++; $display("FAIL full_hold cyc=%0d got grant/wr/ack=%b want 001000000", c, obs[W-1 -: NREQ+1+NREQ]);
        end
      end
    end
    total++;
    if (wq.size() != 4 || wq[0] !== 8'h40 || wq[3] !== 8'h43) begin
      bad++; $display("FAIL full_data got size=%0d want 4 beats 40..43", wq.size());
    end
  endtask

  task automatic test_fifo_depth();
    logic [W-1:0] obs, exp;
    logic [DW-1:0] rd[$];
    for (int i = 0; i < 0; i++) rd.push_back('0);
    apply_reset();
    rem[0] = 20;
    for (int c = 0; c < 60; c++) begin
      step(wq.size() >= 16, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL fifo_depth cyc=%0d got=%h want=%h", c, obs, exp); end
      if (wq.size() > 16) begin total++; bad++; $display("FAIL fifo_overflow got=%0d want<=16", wq.size()); end
      if (c == 24) begin
        total++;
        if (wq.size() != 16) begin bad++; $display("FAIL fifo_stall got=%0d want=16", wq.size()); end
      end
      if (c >= 25 && wq.size() > 0) rd.push_back(wq.pop_front());
    end
    total++;
    if (rd.size() != 20) begin bad++; $display("FAIL fifo_drain got=%0d want=20", rd.size()); end
    for (int k = 0; k < rd.size(); k++) begin
      total++;
      if (rd[k] !== DW'(k)) begin bad++; $display("FAIL fifo_order idx=%0d got=%h want=%h", k, rd[k], DW'(k)); end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] obs, exp;
    apply_reset();
    rem[3] = 4;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mid_reset_pre cyc=%0d got=%h want=%h", c, obs, exp); end
    end
    drive(1'b0);
    rst = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (bus.grant !== 4'b0000 || bus.fifo_wr !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset got grant=%b wr=%b busy=%b want 0000/0/0", bus.grant, bus.fifo_wr, bus.busy);
    end
    rst = 1'b0;
    rem[3] = 0;
    m_own = -1; m_ptr = 0; m_cnt = 0;
    rem[1] = 2; rem[3] = 2;
    for (int c = 0; c < 7; c++) begin
      step(1'b0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL mid_reset_post cyc=%0d got=%h want=%h", c, obs, exp); end
      if (c == 1) begin
        total++;
        if (obs[W-1 -: NREQ] !== 4'b0010) begin bad++; $display("FAIL mid_reset_first got=%b want=0010", obs[W-1 -: NREQ]); end
      end
    end
  endtask

  task automatic test_early_drop();
    logic [W-1:0] obs, exp;
    apply_reset();
    rem[0] = 1; rem[1] = 2;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL early_drop cyc=%0d got=%h want=%h", c, obs, exp); end
      if (c == 2 || c == 3) begin
        total++;
        if (obs[W-1 -: NREQ] !== ((c == 2) ? 4'b0001 : 4'b0010) || obs[DW] !== 1'b1) begin
          bad++; $display("FAIL early_drop_handoff cyc=%0d got grant=%b busy=%b", c, obs[W-1 -: NREQ], obs[DW]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] obs, exp;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 7);
      step($urandom_range(0, 3) == 0, obs, exp);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_own = -1; m_ptr = 0; m_cnt = 0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_fifo_depth();
    test_mid_reset();
    test_early_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
